// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: single-outstanding request/ack handshake.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read, one-word skid buffer
// for consumer back-pressure, and redirect/flush handling.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_if.master        imem,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic [31:0]          instruction,
   output logic [31:0]          instr_pc,
   output logic                 instr_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SKID = 2'd2,
      DROP = 2'd3
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] pending_pc_reg, pending_pc_next;
   logic [31:0] skid_instr_reg, skid_instr_next;
   logic [31:0] skid_pc_reg, skid_pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] instr_pc_reg, instr_pc_next;
   logic        instr_valid_reg, instr_valid_next;
   logic [31:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & ~32'd3;

   // In DROP pc_reg still holds the abandoned address, keeping imem_addr stable.
   assign imem.imem_req  = (state_reg == REQ) || (state_reg == DROP);
   assign imem.imem_addr = pc_reg;

   assign instruction = instr_reg;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = instr_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         pc_reg          <= RESET_PC_ALIGNED;
         pending_pc_reg  <= 32'h0;
         skid_instr_reg  <= 32'h0;
         skid_pc_reg     <= 32'h0;
         instr_reg       <= 32'h0;
         instr_pc_reg    <= RESET_PC_ALIGNED;
         instr_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         pending_pc_reg  <= pending_pc_next;
         skid_instr_reg  <= skid_instr_next;
         skid_pc_reg     <= skid_pc_next;
         instr_reg       <= instr_next;
         instr_pc_reg    <= instr_pc_next;
         instr_valid_reg <= instr_valid_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      pending_pc_next  = pending_pc_reg;
      skid_instr_next  = skid_instr_reg;
      skid_pc_next     = skid_pc_reg;
      instr_next       = instr_reg;
      instr_pc_next    = instr_pc_reg;
      // A word presented without stall is consumed; the output empties unless refilled.
      instr_valid_next = instr_valid_reg && stall;

      if (redirect_valid) begin
         instr_valid_next = 1'b0;
         instr_next       = 32'h0;
         skid_instr_next  = 32'h0;
         skid_pc_next     = 32'h0;
         case (state_reg)
            REQ, DROP: begin
               if (imem.imem_ack) begin
                  state_next      = IDLE;
                  pc_next         = redirect_aligned;
                  pending_pc_next = 32'h0;
               end else begin
                  state_next      = DROP;
                  pending_pc_next = redirect_aligned;
               end
            end
            default: begin
               state_next = IDLE;
               pc_next    = redirect_aligned;
            end
         endcase
      end else begin
         case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
               if (imem.imem_ack) begin
                  pc_next = pc_reg + 32'd4;
                  if (!instr_valid_reg || !stall) begin
                     instr_next       = imem.imem_rdata;
                     instr_pc_next    = pc_reg;
                     instr_valid_next = 1'b1;
                  end else begin
                     skid_instr_next = imem.imem_rdata;
                     skid_pc_next    = pc_reg;
                     state_next      = SKID;
                  end
               end
            end
            SKID: begin
               if (!stall) begin
                  instr_next       = skid_instr_reg;
                  instr_pc_next    = skid_pc_reg;
                  instr_valid_next = 1'b1;
                  state_next       = REQ;
               end
            end
            DROP: begin
               if (imem.imem_ack) begin
                  state_next      = IDLE;
                  pc_next         = pending_pc_reg;
                  pending_pc_next = 32'h0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Scenario bench for instr_fetch: directed memory responses, scoreboard of delivered words.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_valid;

   int checks   = 0;
   int failures = 0;
   bit watch_dead = 1'b0;

   logic [31:0] exp_instr_q[$];
   logic [31:0] exp_pc_q[$];

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (bus),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid)
   );

   always #5 clk = ~clk;

   // Inputs change 2ns after the rising edge; outputs and inputs are both settled here.
   always @(negedge clk) begin
      if (instr_valid === 1'b1 && stall === 1'b0) begin
         checks++;
         if (exp_instr_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got %h@%h want no word", instruction, instr_pc);
         end else begin
            logic [31:0] ei, ep;
            ei = exp_instr_q.pop_front();
            ep = exp_pc_q.pop_front();
            if (instruction !== ei || instr_pc !== ep) begin
               failures++;
               $display("FAIL sb_word: got %h@%h want %h@%h", instruction, instr_pc, ei, ep);
            end else begin
               $display("consumed %h @ %h", instruction, instr_pc);
            end
         end
      end
      if (watch_dead) begin
         checks++;
         if (instr_valid === 1'b1 && instruction === 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL dropped_word_visible: got %h valid=1 want never", instruction);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] ins, input logic [31:0] pc);
      exp_instr_q.push_back(ins);
      exp_pc_q.push_back(pc);
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
      tick(); tick();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
          instruction !== 32'h0 || instr_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: got req=%b addr=%h v=%b ins=%h pc=%h want 0/0/0/0/0",
                  bus.imem_req, bus.imem_addr, instr_valid, instruction, instr_pc);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL first_req: got req=%b addr=%h want 1/00000000", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_sequential();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3401_3000;
      push_exp(32'h3401_3000, 32'h0);
      tick();
      bus.imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 32'h3401_3000 || instr_pc !== 32'h0 ||
          bus.imem_addr !== 32'h4) begin
         failures++;
         $display("FAIL seq_word0: got v=%b ins=%h pc=%h addr=%h want 1/34013000/0/4",
                  instr_valid, instruction, instr_pc, bus.imem_addr);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0 || instruction !== 32'h3401_3000 || bus.imem_req !== 1'b1) begin
         failures++;
         $display("FAIL seq_consumed_gap: got v=%b ins=%h req=%b want 0/34013000/1",
                  instr_valid, instruction, bus.imem_req);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3801_0000;
      push_exp(32'h3801_0000, 32'h4);
      tick();
      bus.imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 32'h3801_0000 || instr_pc !== 32'h4) begin
         failures++;
         $display("FAIL seq_word1: got v=%b ins=%h pc=%h want 1/38010000/4",
                  instr_valid, instruction, instr_pc);
      end
   endtask

   task automatic test_skid();
      stall = 1'b1;
      checks++;
      if (bus.imem_addr !== 32'h8) begin
         failures++;
         $display("FAIL skid_addr: got %h want 00000008", bus.imem_addr);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3001_1020;
      push_exp(32'h3001_1020, 32'h8);
      tick();
      bus.imem_ack = 1'b0;
      checks++;
      if (bus.imem_req !== 1'b0 || instruction !== 32'h3801_0000 || instr_valid !== 1'b1 ||
          bus.imem_addr !== 32'hC) begin
         failures++;
         $display("FAIL skid_hold: got req=%b ins=%h v=%b addr=%h want 0/38010000/1/c",
                  bus.imem_req, instruction, instr_valid, bus.imem_addr);
      end
      // Stray ack with no request outstanding must be ignored.
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0BAD;
      tick();
      bus.imem_ack = 1'b0;
      checks++;
      if (bus.imem_req !== 1'b0 || instruction !== 32'h3801_0000 || bus.imem_addr !== 32'hC) begin
         failures++;
         $display("FAIL stray_ack: got req=%b ins=%h addr=%h want 0/38010000/c",
                  bus.imem_req, instruction, bus.imem_addr);
      end
      stall = 1'b0;
      tick();
      checks++;
      if (instruction !== 32'h3001_1020 || instr_pc !== 32'h8 || instr_valid !== 1'b1 ||
          bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
         failures++;
         $display("FAIL skid_release: got ins=%h pc=%h v=%b req=%b addr=%h want 30011020/8/1/1/c",
                  instruction, instr_pc, instr_valid, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_redirect_outstanding();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h8;
      tick();
      redirect_valid = 1'b0;
      exp_instr_q.delete(); exp_pc_q.delete();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL drop_hold_addr: got req=%b addr=%h v=%b want 1/c/0",
                  bus.imem_req, bus.imem_addr, instr_valid);
      end
      watch_dead = 1'b1;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_ack = 1'b0;
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
         failures++;
         $display("FAIL refetch_8: got req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
         failures++;
         $display("FAIL drop_stable: got req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_ack = 1'b0;
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_addr: got req=%b addr=%h v=%b want 1/100/0",
                  bus.imem_req, bus.imem_addr, instr_valid);
      end
      tick();
      watch_dead = 1'b0;
   endtask

   task automatic test_redirect_ack_stall();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_0001;
      push_exp(32'h1111_0001, 32'h100);
      tick();
      bus.imem_ack = 1'b0;
      stall = 1'b1;
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 32'h1111_0001) begin
         failures++;
         $display("FAIL pre_redirect_word: got v=%b ins=%h want 1/11110001", instr_valid, instruction);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_0002;
      tick();
      redirect_valid = 1'b0; bus.imem_ack = 1'b0; stall = 1'b0;
      exp_instr_q.delete(); exp_pc_q.delete();
      checks++;
      if (instr_valid !== 1'b0 || instruction !== 32'h0 || bus.imem_req !== 1'b0 ||
          bus.imem_addr !== 32'h200) begin
         failures++;
         $display("FAIL redirect_ack_stall: got v=%b ins=%h req=%b addr=%h want 0/0/0/200",
                  instr_valid, instruction, bus.imem_req, bus.imem_addr);
      end
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
         failures++;
         $display("FAIL fetch_200: got req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_wrap_and_reset();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0BAD_F00D;
      tick();
      redirect_valid = 1'b0; bus.imem_ack = 1'b0;
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL fetch_top: got req=%b addr=%h v=%b want 1/fffffffc/0",
                  bus.imem_req, bus.imem_addr, instr_valid);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1357_9BDF;
      push_exp(32'h1357_9BDF, 32'hFFFF_FFFC);
      tick();
      bus.imem_ack = 1'b0;
      checks++;
      if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1 || instruction !== 32'h1357_9BDF ||
          instr_pc !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap: got addr=%h req=%b ins=%h pc=%h want 0/1/13579bdf/fffffffc",
                  bus.imem_addr, bus.imem_req, instruction, instr_pc);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || bus.imem_addr !== 32'h0 ||
          instruction !== 32'h0) begin
         failures++;
         $display("FAIL mid_req_reset: got req=%b v=%b addr=%h ins=%h want 0/0/0/0",
                  bus.imem_req, instr_valid, bus.imem_addr, instruction);
      end
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL post_reset_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_skid();
      test_redirect_outstanding();
      test_redirect_ack_stall();
      test_wrap_and_reset();
      tick();
      checks++;
      if (exp_instr_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover: got %0d words pending want 0", exp_instr_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req  output  1  memory read request; once asserted, it SHALL stay high until imem_ack.
REQ-005 imem_addr  output  32  word-aligned read address; it SHALL be stable while imem_req is high.
REQ-006 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  instruction word returned by memory.
REQ-008 stall  input  1  consumer (control decoder) cannot accept; output registers hold.
REQ-009 redirect_valid  input  1  one-cycle pulse: branch or jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored (treated as 0).
REQ-011 instruction  output  32  registered instruction word driven to the control decoder.
REQ-012 instr_pc  output  32  address of the word on instruction.
REQ-013 instr_valid  output  1  instruction/instr_pc hold a live word.

Function
REQ-014 At most one memory request SHALL be outstanding; the state machine SHALL have states IDLE, REQ, SKID and DROP.
REQ-015 IDLE: imem_req=0; the FSM SHALL go unconditionally to REQ on the next cycle.
REQ-016 REQ: imem_req=1 and imem_addr=pc.
REQ-017 REQ, on ack with (!instr_valid || !stall): load instruction=imem_rdata, instr_pc=pc and instr_valid=1, set pc=pc+4, and stay in REQ.
REQ-018 REQ, on ack with instr_valid && stall: capture rdata/pc into the skid register, set pc=pc+4, and go to SKID.
REQ-019 REQ, with no ack and a consumed output (instr_valid && !stall): instr_valid SHALL drop to 0 next cycle and instruction SHALL hold its last value.
REQ-020 SKID: imem_req=0; on !stall the skid word SHALL move to the output with instr_valid=1, and the FSM SHALL go to REQ.
REQ-021 A word SHALL count as consumed only in a cycle with instr_valid=1 and stall=0; no word SHALL be dropped or duplicated.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect SHALL have priority over stall and ack.
  - Effects next cycle: instr_valid=0, instruction=32'h0, skid cleared, pc=redirect_pc & ~3.
REQ-024 Redirect in REQ with ack in the same cycle: the response SHALL be discarded and the FSM SHALL go to IDLE, then REQ at the new pc.
REQ-025 Redirect in REQ without ack: the FSM SHALL go to DROP.
  - imem_req stays 1 and imem_addr holds the old address until ack.
  - The new pc is saved as pending.
REQ-026 DROP: on ack, the data SHALL be discarded and the FSM SHALL go to IDLE.
  - A further redirect in DROP SHALL overwrite the pending pc.
  - Redirect and ack in the same cycle: the data is discarded, the new pc is taken, and the FSM goes to IDLE.
REQ-027 Redirect in SKID or IDLE: the FSM SHALL go to IDLE with the new pc.
REQ-028 An imem_ack received while imem_req=0 SHALL be ignored.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter the following reset state:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC;
  - instruction=32'h0, instr_pc=RESET_PC, instr_valid=0, skid and pending pc cleared.
REQ-030 Reset mid-request SHALL abandon the outstanding request without waiting for ack.
  - Memory SHALL be reset together with this block.
REQ-031 rst SHALL override redirect_valid, imem_ack and stall.

Verification
REQ-032 Sequential fetch. Reset, then ack each request one cycle later with 32'h3401_3000 and 32'h3801_0000:
  - imem_addr SHALL read 0x0 then 0x4;
  - instruction/instr_pc SHALL read 32'h3401_3000/0x0, then 32'h3801_0000/0x4.
REQ-033 Stall and skid. Hold stall=1 with the output valid while an ack returns 32'h3001_1020:
  - the output SHALL hold its word, imem_req SHALL be 0 in SKID, and pc SHALL have advanced by 4;
  - after stall=0, instruction SHALL become 32'h3001_1020 in the next cycle.
REQ-034 Redirect with a request outstanding. Pulse redirect_pc=0x100 in REQ at address 0x8, then ack two cycles later with 32'hDEAD_BEEF:
  - 32'hDEAD_BEEF SHALL never appear with instr_valid=1;
  - the next imem_addr SHALL be 0x100.
REQ-035 Redirect coincident with ack and stall. Apply redirect_pc=0x203, ack and stall=1 in the same cycle:
  - instr_valid SHALL be 0 next cycle and the next fetch SHALL be at 0x200.
REQ-036 Wrap-around and mid-request reset:
  - redirect to 0xFFFF_FFFC and ack it: the next imem_addr SHALL be 0x0;
  - assert rst while imem_req=1: imem_req=0 and instr_valid=0 on the following cycle.
